fft_iter_ctrl: RTL

//  Sequencer that time-multiplexes one runtime-step butterfly stage over all NPOINT radix-2

---
 rtl/fft_iter_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fft_iter_ctrl.sv
// fft_iter_ctrl: sequences one runtime-configurable radix-2 butterfly stage over all
// NPOINT stages of a 2**NPOINT-point FFT, holding the frame in an in-place buffer.
// Optional build macro: FFT_ITER_CTRL_BITREV_EN (bit-reversed load of the input frame).
module fft_iter_ctrl #(
    parameter int WIDTH  = 16,
    parameter int NPOINT = 3,
    localparam int SW    = (NPOINT > 1) ? $clog2(NPOINT) : 1,
    localparam int FW    = WIDTH * (2 ** NPOINT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          din_valid,
    output logic          din_busy,
    input  logic [FW-1:0] din_real,
    input  logic [FW-1:0] din_imag,
    output logic          bf_valid,
    input  logic          bf_busy,
    output logic [FW-1:0] bf_real,
    output logic [FW-1:0] bf_imag,
    output logic [SW-1:0] bf_step,
    input  logic          bf_dout_valid,
    output logic          bf_dout_busy,
    input  logic [FW-1:0] bf_dout_real,
    input  logic [FW-1:0] bf_dout_imag,
    output logic          dout_valid,
    input  logic          dout_busy,
    output logic [FW-1:0] dout_real,
    output logic [FW-1:0] dout_imag
);

    localparam int            NS        = 2 ** NPOINT;
    localparam logic [SW-1:0] LAST_STEP = SW'(NPOINT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } state_t;

    state_t        state, state_nx;
    logic [SW-1:0] step, step_nx;
    logic [FW-1:0] frame_real, frame_imag;
    logic [FW-1:0] frame_real_nx, frame_imag_nx;

    logic din_xfer, bf_xfer, bf_dout_xfer, dout_xfer;

    // Arrange an incoming frame into buffer order (bit-reversed slots when enabled).
    function automatic logic [FW-1:0] load_order(input logic [FW-1:0] f);
`ifdef FFT_ITER_CTRL_BITREV_EN
        logic [FW-1:0] o;
        int unsigned   rk;
        o = '0;
        for (int unsigned k = 0; k < NS; k++) begin
            rk = 0;
            for (int unsigned b = 0; b < NPOINT; b++) begin
                if (((k >> b) & 1) != 0) rk |= (1 << (NPOINT - 1 - b));
            end
            o[rk*WIDTH +: WIDTH] = f[k*WIDTH +: WIDTH];
        end
        return o;
`else
        return f;
`endif
    endfunction

    assign din_xfer     = din_valid && !din_busy;
    assign bf_xfer      = bf_valid && !bf_busy;
    assign bf_dout_xfer = bf_dout_valid && !bf_dout_busy;
    assign dout_xfer    = dout_valid && !dout_busy;

    // The buffer is presented unchanged to both the stage and the sink.
    assign bf_real   = frame_real;
    assign bf_imag   = frame_imag;
    assign dout_real = frame_real;
    assign dout_imag = frame_imag;
    assign bf_step   = step;

    // Next-state, step and buffer update for the frame sequencer.
    always_comb begin
        state_nx      = state;
        step_nx       = step;
        frame_real_nx = frame_real;
        frame_imag_nx = frame_imag;
        case (state)
            IDLE: begin
                if (din_xfer) begin
                    frame_real_nx = load_order(din_real);
                    frame_imag_nx = load_order(din_imag);
                    step_nx       = '0;
                    state_nx      = ISSUE;
                end
            end
            ISSUE: begin
                if (bf_xfer) state_nx = WAIT;
            end
            WAIT: begin
                if (bf_dout_xfer) begin
                    frame_real_nx = bf_dout_real;
                    frame_imag_nx = bf_dout_imag;
                    if (step == LAST_STEP) begin
                        state_nx = OUT;
                    end else begin
                        step_nx  = step + SW'(1);
                        state_nx = ISSUE;
                    end
                end
            end
            OUT: begin
                if (dout_xfer) begin
                    step_nx  = '0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, buffer and handshake registers; controls decode from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            step         <= '0;
            frame_real   <= '0;
            frame_imag   <= '0;
            din_busy     <= 1'b0;
            bf_valid     <= 1'b0;
            bf_dout_busy <= 1'b1;
            dout_valid   <= 1'b0;
        end else begin
            state        <= state_nx;
            step         <= step_nx;
            frame_real   <= frame_real_nx;
            frame_imag   <= frame_imag_nx;
            din_busy     <= (state_nx != IDLE);
            bf_valid     <= (state_nx == ISSUE);
            bf_dout_busy <= (state_nx != WAIT);
            dout_valid   <= (state_nx == OUT);
        end
    end

endmodule
